max11046_responder: RTL and testbench

- Synthesizable stand-in for the MAX11046 8-channel ADC.
- Sits on the ADC side of the CONVST/CS/RD/WR/DB/EOC bus and answers the FPGA-side MAX11046 controller.
- Lets the force-measurement readout chain be exercised on hardware and in simulation without the real converter.
- Models conversion time, the EOC handshake, sequential channel readout, the configuration write and deterministic per-channel sample data.

---
 rtl/max11046_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_max11046_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/max11046_responder.sv
// ---------------------------------------------------------------------------
// max11046_responder
// ADC-side stand-in for the MAX11046 8-channel converter. It answers the
// FPGA-side controller on the CONVST/CS/RD/WR/DB/EOC bus with a modelled
// conversion time, the EOC handshake, sequential channel readout, a
// configuration register and deterministic sample words of the form
// {channel[2:0], frame_cnt[12:0]}.
// ---------------------------------------------------------------------------
module max11046_responder #(
  parameter int NUM_CH      = 8,    // channels per conversion, 1..8
  parameter int CONV_CYCLES = 400   // conversion time in clocks, >= 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        conv_start,
  input  logic        chip_sel,
  input  logic        read_s,
  input  logic        write,
  input  logic [15:0] db_in,
  output logic [15:0] db_out,
  output logic        db_oe,
  output logic        end_of_con,
  output logic [15:0] cfg_word,
  output logic [12:0] frame_cnt,
  output logic        overrun
);

  // Counter just wide enough to hold CONV_CYCLES-1.
  localparam int               CNT_W    = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LAST_PTR = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_READY,
    S_READOUT
  } state_t;

  // ---------------------------------------------------------------------
  // Input sampling and edge detection
  // ---------------------------------------------------------------------
  logic        r_conv_s, r_conv_d;
  logic        r_rd_s,   r_rd_d;
  logic        r_wr_s,   r_wr_d;
  logic        r_cs_s;
  logic [15:0] r_db_s;

  // Sample every bus input once, then keep a delayed copy for edge strobes.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register sees the pre-edge value of the others and the two-stage
  // sampler really is two stages.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_s <= 1'b0;
      r_conv_d <= 1'b0;
      r_rd_s   <= 1'b1;
      r_rd_d   <= 1'b1;
      r_wr_s   <= 1'b1;
      r_wr_d   <= 1'b1;
      r_cs_s   <= 1'b1;
      r_db_s   <= 16'h0000;
    end else begin
      r_conv_s <= conv_start;
      r_conv_d <= r_conv_s;
      r_rd_s   <= read_s;
      r_rd_d   <= r_rd_s;
      r_wr_s   <= write;
      r_wr_d   <= r_wr_s;
      r_cs_s   <= chip_sel;
      r_db_s   <= db_in;
    end
  end

  logic w_conv_rise;
  logic w_conflict;
  logic w_rd_fall;
  logic w_rd_rise;
  logic w_wr_rise;
  logic w_oe;

  // RD and WR low together with CS low is a bus fight: it drives nothing and
  // must not be mistaken for a read start.
  assign w_conv_rise = r_conv_s & ~r_conv_d;
  assign w_conflict  = ~r_cs_s & ~r_rd_s & ~r_wr_s;
  assign w_rd_fall   = ~r_cs_s & ~r_rd_s &  r_rd_d & r_wr_s;
  assign w_rd_rise   = ~r_cs_s &  r_rd_s & ~r_rd_d;
  assign w_wr_rise   = ~r_cs_s &  r_wr_s & ~r_wr_d;
  assign w_oe        = ~r_cs_s & ~r_rd_s &  r_wr_s;

  // ---------------------------------------------------------------------
  // Conversion / readout state machine
  // ---------------------------------------------------------------------
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]       r_ptr,   w_ptr_nxt;
  logic             r_eoc,   w_eoc_nxt;
  logic [12:0]      r_frame, w_frame_nxt;
  logic             r_ovr,   w_ovr_nxt;

  // Hold the FSM state together with the counter, pointer, EOC and flags.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= 3'd0;
      r_eoc   <= 1'b1;
      r_frame <= 13'd0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_eoc   <= w_eoc_nxt;
      r_frame <= w_frame_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // Next-state and next-register logic for conversion and readout.
  // NOTE: every signal gets its hold value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_eoc_nxt   = r_eoc;
    w_frame_nxt = r_frame;
    w_ovr_nxt   = r_ovr | w_conflict;

    unique case (r_state)
      S_IDLE: begin
        if (w_conv_rise) begin
          w_state_nxt = S_CONVERT;
          w_cnt_nxt   = CNT_LOAD;
        end else if (w_rd_rise) begin
          // Re-reading after a completed readout walks the channels again.
          w_ptr_nxt = (r_ptr == LAST_PTR) ? 3'd0 : r_ptr + 3'd1;
        end
      end

      S_CONVERT: begin
        // A second CONVST while busy is dropped but remembered as an overrun.
        if (w_conv_rise) begin
          w_ovr_nxt = 1'b1;
        end
        if (r_cnt == '0) begin
          w_state_nxt = S_READY;
          w_eoc_nxt   = 1'b0;
          w_frame_nxt = r_frame + 13'd1;
          w_ptr_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      S_READY: begin
        // Restart wins over a simultaneous read; no channel was read, so
        // the whole frame was lost.
        if (w_conv_rise) begin
          w_state_nxt = S_CONVERT;
          w_cnt_nxt   = CNT_LOAD;
          w_eoc_nxt   = 1'b1;
          w_ptr_nxt   = 3'd0;
          w_ovr_nxt   = 1'b1;
        end else if (w_rd_fall) begin
          w_state_nxt = S_READOUT;
          w_eoc_nxt   = 1'b1;
        end
      end

      S_READOUT: begin
        if (w_conv_rise) begin
          w_state_nxt = S_CONVERT;
          w_cnt_nxt   = CNT_LOAD;
          w_eoc_nxt   = 1'b1;
          w_ptr_nxt   = 3'd0;
        end else if (w_rd_rise) begin
          if (r_ptr == LAST_PTR) begin
            w_ptr_nxt   = 3'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_ptr_nxt = r_ptr + 3'd1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Bus-facing registers
  // ---------------------------------------------------------------------
  logic [15:0] r_db_out;
  logic        r_db_oe;
  logic [15:0] r_cfg;

  // Drive the sample word only while a clean read is in progress; hold 0
  // otherwise so the tristate buffer never sees stale data.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_db_out <= 16'h0000;
      r_db_oe  <= 1'b0;
    end else begin
      r_db_oe  <= w_oe;
      r_db_out <= w_oe ? {r_ptr, r_frame} : 16'h0000;
    end
  end

  // Capture the configuration word on a chip-selected WR rise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg <= 16'h0000;
    end else if (w_wr_rise) begin
      r_cfg <= r_db_s;
    end
  end

  assign db_out     = r_db_out;
  assign db_oe      = r_db_oe;
  assign end_of_con = r_eoc;
  assign cfg_word   = r_cfg;
  assign frame_cnt  = r_frame;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_max11046_responder.sv
// ---------------------------------------------------------------------------
// Self-checking bench for max11046_responder. A transaction-level model
// (frame count, reads since the last completed conversion, config word,
// sticky overrun) predicts every observed value.
// ---------------------------------------------------------------------------
module tb_max11046_responder;

  localparam int NUM_CH      = 8;
  localparam int CONV_CYCLES = 400;

  logic        clock;
  logic        rst_n;
  logic        conv_start;
  logic        chip_sel;
  logic        read_s;
  logic        write;
  logic [15:0] db_in;
  logic [15:0] db_out;
  logic        db_oe;
  logic        end_of_con;
  logic [15:0] cfg_word;
  logic [12:0] frame_cnt;
  logic        overrun;

  max11046_responder #(
    .NUM_CH      (NUM_CH),
    .CONV_CYCLES (CONV_CYCLES)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .conv_start (conv_start),
    .chip_sel   (chip_sel),
    .read_s     (read_s),
    .write      (write),
    .db_in      (db_in),
    .db_out     (db_out),
    .db_oe      (db_oe),
    .end_of_con (end_of_con),
    .cfg_word   (cfg_word),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state.
  int          m_frame;      // completed conversions, mod 8192
  int          m_reads;      // reads since the last completed conversion
  bit          m_have_data;  // at least one conversion completed since reset
  bit          m_ovr;
  logic [15:0] m_cfg;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_frame     = 0;
    m_reads     = 0;
    m_have_data = 0;
    m_ovr       = 0;
    m_cfg       = 16'h0000;
  endtask

  // One CONVST pulse; optionally a second pulse 'extra_at' cycles later
  // while the conversion is running. Measures EOC fall latency.
  task automatic do_conv(input int extra_at);
    bit was_ready;
    bit seen;
    int cnt;
    was_ready = m_have_data && (m_reads == 0);
    seen = 0;
    cnt  = 0;
    @(posedge clock);
    #1 conv_start = 1'b1;
    while (cnt < CONV_CYCLES + 50) begin
      @(posedge clock);
      #1;
      cnt++;
      if (cnt == 3) conv_start = 1'b0;
      if (extra_at > 0 && cnt == extra_at)     conv_start = 1'b1;
      if (extra_at > 0 && cnt == extra_at + 3) conv_start = 1'b0;
      if (cnt == 2) check("eoc_high_after_start", 32'(end_of_con), 32'd1);
      if (cnt >= 2 && !end_of_con) begin
        seen = 1;
        break;
      end
    end
    conv_start = 1'b0;
    check("eoc_latency", seen ? 32'(cnt - 1) : 32'hFFFF_FFFF, 32'(CONV_CYCLES + 1));
    if (was_ready || extra_at > 0) m_ovr = 1;
    m_frame     = (m_frame + 1) % 8192;
    m_reads     = 0;
    m_have_data = 1;
    check("frame_cnt", 32'(frame_cnt), 32'(m_frame));
    check("overrun_conv", 32'(overrun), 32'(m_ovr));
  endtask

  // One chip-selected RD pulse, lo cycles low and hi cycles high.
  task automatic do_read(input int lo, input int hi);
    logic [15:0] exp_word;
    exp_word = {3'(m_reads % NUM_CH), 13'(m_frame)};
    @(posedge clock);
    #1;
    chip_sel = 1'b0;
    read_s   = 1'b0;
    tick(lo);
    check("rd_oe", 32'(db_oe), 32'd1);
    check("rd_data", 32'(db_out), 32'(exp_word));
    check("rd_eoc", 32'(end_of_con), 32'd1);
    read_s = 1'b1;
    tick(hi);
    check("rd_oe_off", 32'(db_oe), 32'd0);
    check("rd_bus_zero", 32'(db_out), 32'd0);
    chip_sel = 1'b1;
    m_reads++;
  endtask

  // One WR pulse of 3 cycles, with CS low or high.
  task automatic do_cfg(input logic [15:0] d, input bit cs_low);
    @(posedge clock);
    #1;
    db_in    = d;
    chip_sel = cs_low ? 1'b0 : 1'b1;
    write    = 1'b0;
    tick(3);
    write = 1'b1;
    tick(3);
    chip_sel = 1'b1;
    if (cs_low) m_cfg = d;
    check("cfg_word", 32'(cfg_word), 32'(m_cfg));
  endtask

  // RD and WR low together with CS low; only used while the device is idle.
  task automatic do_conflict();
    @(posedge clock);
    #1;
    db_in    = 16'($urandom);
    chip_sel = 1'b0;
    read_s   = 1'b0;
    write    = 1'b0;
    tick(3);
    check("conflict_oe", 32'(db_oe), 32'd0);
    check("conflict_bus", 32'(db_out), 32'd0);
    chip_sel = 1'b1;
    tick(1);
    read_s = 1'b1;
    write  = 1'b1;
    tick(3);
    m_ovr = 1;
    check("conflict_ovr", 32'(overrun), 32'(m_ovr));
    check("conflict_cfg", 32'(cfg_word), 32'(m_cfg));
  endtask

  initial begin
    rst_n      = 1'b0;
    conv_start = 1'b0;
    chip_sel   = 1'b1;
    read_s     = 1'b1;
    write      = 1'b1;
    db_in      = 16'h0000;
    model_reset();
    tick(3);

    check("rst_eoc", 32'(end_of_con), 32'd1);
    check("rst_oe", 32'(db_oe), 32'd0);
    check("rst_bus", 32'(db_out), 32'd0);
    check("rst_cfg", 32'(cfg_word), 32'd0);
    check("rst_frame", 32'(frame_cnt), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // First conversion and a full eight-channel readout.
    do_conv(0);
    for (int i = 0; i < 8; i++) do_read(4, $urandom_range(2, 4));

    // Second conversion, ten reads: wraps back to channel 0.
    do_conv(0);
    for (int i = 0; i < 10; i++) do_read(4, $urandom_range(2, 4));
    check("ovr_clean", 32'(overrun), 32'd0);

    // Configuration write, then the same pulse with CS high.
    do_cfg(16'hA5C3, 1'b1);
    do_cfg(16'h5A3C, 1'b0);

    // Randomised mix of conversions, reads, writes and bus conflicts.
    for (int it = 0; it < 14; it++) begin
      int sel;
      sel = $urandom_range(0, 3);
      if (sel <= 1) begin
        int nrd;
        do_conv(0);
        nrd = $urandom_range(0, 12);
        for (int r = 0; r < nrd; r++) do_read($urandom_range(2, 5), $urandom_range(2, 5));
      end else if (sel == 3 && (!m_have_data || m_reads >= NUM_CH)) begin
        do_conflict();
      end else begin
        do_cfg(16'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    // Extra CONVST mid-conversion, then a restart from READY.
    do_conv(150);
    do_conv(0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset in READOUT while the bus is being driven.
    do_read(3, 3);
    @(posedge clock);
    #1;
    chip_sel = 1'b0;
    read_s   = 1'b0;
    tick(3);
    check("pre_rst_oe", 32'(db_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", 32'(db_oe), 32'd0);
    check("rst_mid_eoc", 32'(end_of_con), 32'd1);
    check("rst_mid_frame", 32'(frame_cnt), 32'd0);
    check("rst_mid_ovr", 32'(overrun), 32'd0);
    read_s   = 1'b1;
    chip_sel = 1'b1;
    model_reset();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    do_conv(0);
    do_read(4, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
